// File: rtl/sobel_pkg.sv
// Shared types and width helpers for the streaming Sobel edge filter.
package sobel_pkg;

  typedef enum logic [1:0] {
    MODE_SUM    = 2'd0,
    MODE_THRESH = 2'd1,
    MODE_GX     = 2'd2,
    MODE_GY     = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH,
    ST_DONE
  } state_e;

  // A 1-2-1 column sum needs two guard bits; the signed difference needs one more.
  localparam int GRAD_GUARD = 3;

  function automatic int grad_w(input int pix_w);
    return pix_w + GRAD_GUARD;
  endfunction

  function automatic int mag_w(input int pix_w);
    return pix_w + GRAD_GUARD - 1;
  endfunction

endpackage

// File: rtl/sobel_stream_if.sv
// Pixel-in / pixel-out handshake bundle; slave is the filter, master is the environment.
interface sobel_stream_if #(
  parameter int PIX_W = 8
);
  logic             s_valid;
  logic             s_ready;
  logic [PIX_W-1:0] s_data;
  logic             m_valid;
  logic             m_ready;
  logic [PIX_W-1:0] m_data;
  logic             m_last;
  logic             m_eof;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_last, m_eof
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_last, m_eof
  );
endinterface

// File: rtl/sobel_line_buf.sv
// One image row of storage; the read returns the old word when written at the same address.
module sobel_line_buf #(
  parameter int PIX_W = 8,
  parameter int MAX_W = 1024
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(MAX_W)-1:0] waddr,
  input  logic [PIX_W-1:0]         wdata,
  input  logic [$clog2(MAX_W)-1:0] raddr,
  output logic [PIX_W-1:0]         rdata
);

  logic [PIX_W-1:0] mem [MAX_W];

  // NOTE: the storage array is deliberately not reset; every word is written
  // before it can reach an output, and a reset port would block RAM inference.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sobel_stream.sv
// Raster-order 3x3 Sobel filter: two line buffers feed a sliding window, one output per full window.
module sobel_stream
  import sobel_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int MAX_W = 1024,
  parameter int DIM_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [DIM_W-1:0] img_w,
  input  logic [DIM_W-1:0] img_h,
  input  logic [1:0]       mode,
  input  logic [PIX_W+2:0] thresh,
  sobel_stream_if.slave    st,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int GW = grad_w(PIX_W);
  localparam int MW = mag_w(PIX_W);
  localparam int AW = $clog2(MAX_W);
  localparam logic [GW-1:0] PIX_MAX = GW'((1 << PIX_W) - 1);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [DIM_W-1:0] w_q, w_d, h_q, h_d;
  logic [DIM_W-1:0] col_q, col_d, row_q, row_d;
  logic [GW-1:0]    thresh_q, thresh_d;
  logic             m_valid_q, m_valid_d, m_last_q, m_last_d, m_eof_q, m_eof_d;
  logic [PIX_W-1:0] m_data_q, m_data_d;
  logic             busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [PIX_W-1:0] win_q [3][3];
  logic [PIX_W-1:0] win_d [3][3];
  logic [PIX_W-1:0] win_n [3][3];

  logic             s_fire, at_row_end, last_pix, produce, geom_ok;
  logic [PIX_W-1:0] lb0_rd, lb1_rd, pix_res;
  logic signed [GW-1:0] gx, gy;
  logic [MW-1:0]    ax, ay;
  logic [GW-1:0]    sum_g;

  function automatic logic [GW-1:0] wsum(input logic [PIX_W-1:0] a, b, c);
    return GW'(a) + (GW'(b) << 1) + GW'(c);
  endfunction

  function automatic logic [MW-1:0] mag(input logic signed [GW-1:0] g);
    return g[GW-1] ? MW'(-g) : MW'(g);
  endfunction

  function automatic logic [PIX_W-1:0] sat(input logic [GW-1:0] x);
    return (x > PIX_MAX) ? {PIX_W{1'b1}} : x[PIX_W-1:0];
  endfunction

  assign st.s_ready = (state_q == ST_RUN) && (!m_valid_q || st.m_ready);
  assign s_fire     = st.s_valid && st.s_ready;
  assign at_row_end = (col_q == w_q - DIM_W'(1));
  assign last_pix   = at_row_end && (row_q == h_q - DIM_W'(1));
  assign produce    = s_fire && (row_q >= DIM_W'(2)) && (col_q >= DIM_W'(2));
  assign geom_ok    = (img_w >= DIM_W'(3)) && (img_w <= DIM_W'(MAX_W)) && (img_h >= DIM_W'(3));

  // lb0 holds row r-1; on each pixel it ages into lb1, which then holds row r-2.
  sobel_line_buf #(.PIX_W(PIX_W), .MAX_W(MAX_W)) u_lb0 (
    .clk  (clk),
    .we   (s_fire),
    .waddr(col_q[AW-1:0]),
    .wdata(st.s_data),
    .raddr(col_q[AW-1:0]),
    .rdata(lb0_rd)
  );

  sobel_line_buf #(.PIX_W(PIX_W), .MAX_W(MAX_W)) u_lb1 (
    .clk  (clk),
    .we   (s_fire),
    .waddr(col_q[AW-1:0]),
    .wdata(lb0_rd),
    .raddr(col_q[AW-1:0]),
    .rdata(lb1_rd)
  );

  // The window as it will be after this pixel; the output is computed from it directly.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      win_n[r][0] = win_q[r][1];
      win_n[r][1] = win_q[r][2];
    end
    win_n[0][2] = lb1_rd;
    win_n[1][2] = lb0_rd;
    win_n[2][2] = st.s_data;
  end

  always_comb begin
    gx    = $signed(wsum(win_n[0][2], win_n[1][2], win_n[2][2])
                  - wsum(win_n[0][0], win_n[1][0], win_n[2][0]));
    gy    = $signed(wsum(win_n[2][0], win_n[2][1], win_n[2][2])
                  - wsum(win_n[0][0], win_n[0][1], win_n[0][2]));
    ax    = mag(gx);
    ay    = mag(gy);
    sum_g = GW'(ax) + GW'(ay);
    case (mode_q)
      MODE_SUM:    pix_res = sat(sum_g);
      MODE_THRESH: pix_res = (sum_g >= thresh_q) ? {PIX_W{1'b1}} : '0;
      MODE_GX:     pix_res = sat(GW'(ax));
      MODE_GY:     pix_res = sat(GW'(ay));
      default:     pix_res = '0;
    endcase
  end

  // NOTE: every signal assigned below gets its hold value first, so no path
  // through the block leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    w_d       = w_q;
    h_d       = h_q;
    thresh_d  = thresh_q;
    col_d     = col_q;
    row_d     = row_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    m_eof_d   = m_eof_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    win_d     = win_q;

    if (st.m_ready) m_valid_d = 1'b0;
    if (produce) begin
      m_valid_d = 1'b1;
      m_data_d  = pix_res;
      m_last_d  = at_row_end;
      m_eof_d   = last_pix;
    end

    if (s_fire) begin
      win_d = win_n;
      if (at_row_end) begin
        col_d = '0;
        row_d = row_q + DIM_W'(1);
      end else begin
        col_d = col_q + DIM_W'(1);
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (geom_ok) begin
            state_d  = ST_RUN;
            w_d      = img_w;
            h_d      = img_h;
            mode_d   = mode_e'(mode);
            thresh_d = thresh;
            col_d    = '0;
            row_d    = '0;
          end else begin
            err_d  = 1'b1;
            done_d = 1'b1;
          end
        end
      end
      ST_RUN:   if (s_fire && last_pix) state_d = ST_FLUSH;
      ST_FLUSH: begin
        if (!m_valid_q || st.m_ready) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_RUN) || (state_d == ST_FLUSH);
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_SUM;
      w_q       <= '0;
      h_q       <= '0;
      thresh_q  <= '0;
      col_q     <= '0;
      row_q     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
      m_eof_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      w_q       <= w_d;
      h_q       <= h_d;
      thresh_q  <= thresh_d;
      col_q     <= col_d;
      row_q     <= row_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
      m_eof_q   <= m_eof_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Window contents are stale until two columns of a row have arrived, and no output is taken before then.
  always_ff @(posedge clk) begin
    win_q <= win_d;
  end

  assign st.m_valid = m_valid_q;
  assign st.m_data  = m_data_q;
  assign st.m_last  = m_last_q;
  assign st.m_eof   = m_eof_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: doc/sobel_stream.md
SOBEL_STREAM -- requirements
Module: sobel_stream

Interface
REQ-001 Parameter: PIX_W, 8, pixel bit width (4..12).
REQ-002 Parameter: MAX_W, 1024, maximum image width in pixels; sets line-buffer depth.
REQ-003 Parameter: DIM_W, 16, width of the img_w/img_h inputs.
REQ-004 Port: clk  in  1  clock; all logic is rising-edge.
REQ-005 Port: rstn  in  1  reset, synchronous, active-low.
REQ-006 Port: start  in  1  one-cycle frame start; honoured only in IDLE.
REQ-007 Port: img_w, img_h  in  DIM_W each  frame geometry; sampled on an accepted start.
REQ-008 Port: mode  in  2  0=|Gx|+|Gy|, 1=threshold binary, 2=|Gx| only, 3=|Gy| only; sampled on start.
REQ-009 Port: thresh  in  PIX_W+3  threshold for mode 1; sampled on start.
REQ-010 Port: s_valid, s_ready  in, out  1 each  input pixel handshake, raster order.
REQ-011 Port: s_data  in  PIX_W  input pixel.
REQ-012 Port: m_valid, m_ready  out, in  1 each  output pixel handshake.
REQ-013 Port: m_data  out  PIX_W  filtered pixel.
REQ-014 Port: m_last, m_eof  out  1 each  last output of a row; last output of the frame.
REQ-015 Port: busy, done, err  out  1 each  frame in progress; one-cycle end pulse; one-cycle bad-geometry pulse.

Function
REQ-016 States: IDLE, RUN, FLUSH, DONE. IDLE->RUN on start with legal geometry; RUN->FLUSH when pixel (img_h-1, img_w-1) is accepted; FLUSH->DONE when the output register is empty; DONE->IDLE after one cycle, with done=1 in that cycle.
REQ-017 Legal geometry: 3<=img_w<=MAX_W and img_h>=3. Otherwise err=1 and done=1 for one cycle, state stays IDLE, and no pixel is accepted or emitted.
REQ-018 start outside IDLE is ignored; busy=1 in RUN and FLUSH only.
REQ-019 s_ready = (state==RUN) && (!m_valid || m_ready). A pixel transfers when s_valid && s_ready.
REQ-020 Two line buffers of MAX_W x PIX_W hold the previous two rows. A 3x3 window register shifts one column per accepted pixel; row/column counters wrap column at img_w-1.
REQ-021 Only full windows produce output: (img_w-2)*(img_h-2) pixels per frame, centred at (r-1,c-1) and produced when pixel (r,c) is accepted with r>=2 and c>=2.
REQ-022 Latency: m_valid asserts the cycle after the producing input transfer. m_data, m_last and m_eof stay stable while m_valid && !m_ready.
REQ-023 Arithmetic: Gx = (p02+2p12+p22)-(p00+2p10+p20) and Gy = (p20+2p21+p22)-(p00+2p01+p02), signed, PIX_W+3 bits. |Gx| and |Gy| are unsigned PIX_W+2 bits; the mode 0 sum is PIX_W+3 bits.
REQ-024 Modes 0, 2 and 3 saturate the result to 2^PIX_W-1. Mode 1 outputs all-ones if |Gx|+|Gy| >= thresh, else 0.
REQ-025 m_last=1 on output column img_w-3; m_eof=1 on the final output, together with m_last.
REQ-026 The frame-start row/column position is taken from the counters; line-buffer contents from a previous frame never contribute, because rows 0-1 produce no output.

Reset
REQ-027 When rstn=0 at a clock edge: state=IDLE, counters=0, m_valid=0, m_data=0, m_last=0, m_eof=0, busy=0, done=0, err=0, s_ready=0.
REQ-028 Reset mid-frame discards all partial data; line-buffer RAM is not cleared. A subsequent start produces a correct frame.

Structure
REQ-029 A shared package sobel_pkg holds the mode encodings, the state enum, and the derived widths (PIX_W+3 gradient width).
REQ-030 One sub-module, sobel_line_buf: single-clock RAM, one read and one write port, depth MAX_W, read-before-write at the same address; it is instantiated twice.

Verification
REQ-031 4x4 frame, all pixels 100, mode 0 -> 4 outputs of 0; m_last on outputs 2 and 4; m_eof on output 4; done one cycle after the last handshake.
REQ-032 5x3 frame, every row 0,0,255,255,255, mode 0 -> outputs 255,255,0; third has m_last=m_eof=1.
REQ-033 3x3 frame, rows 0/10/20, mode 1: thresh=50 -> single output 255; thresh=100 -> 0; mode 3 -> 80; mode 2 -> 0.
REQ-034 Random 8x6 frame with m_ready low for 10 cycles mid-row -> s_ready low throughout, m_data held, 24 outputs match the reference model.
REQ-035 img_w=2 start -> err and done pulse in the same cycle, busy stays 0, s_ready stays 0, no m_valid.
REQ-036 rstn low for 1 cycle midway through a 6x6 frame, then a new 6x6 start -> 16 outputs correct, no stale m_valid.
